// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory responder and its round-robin arbiter.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRespond,
    StDone
  } state_e;

  // Bits needed to index n items; never less than one.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting slot at or after ptr_i, wrapping.
module rr_arbiter import mem_responder_pkg::*; #(
  parameter int unsigned N = 8,
  localparam int unsigned IdxW = idx_bits(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  input  logic            en_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o
);

  int unsigned    s;
  logic [IdxW-1:0] si;
  logic           found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    s     = 0;
    si    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      s  = (32'(ptr_i) + k) % N;
      si = IdxW'(s);
      if (en_i && !found && req_i[si]) begin
        found     = 1'b1;
        gnt_o[si] = 1'b1;
        idx_o     = si;
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Single-port memory serving per-channel read/write valid/ready ports one request at a time,
// round-robin across slots (2i = read i, 2i+1 = write i) with a fixed access latency.
module mem_responder import mem_responder_pkg::*; #(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned LATENCY       = 2,
  parameter bit          WRITABLE      = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  input  logic                                    init_write_en,
  input  logic [ADDR_BITS-1:0]                    init_address,
  input  logic [DATA_BITS-1:0]                    init_data,
  output logic                                    busy
);

  localparam int unsigned NumSlots = 2 * NUM_CONSUMERS;
  localparam int unsigned SlotW    = idx_bits(NumSlots);
  localparam int unsigned ChW      = idx_bits(NUM_CONSUMERS);
  localparam int unsigned CntW     = idx_bits(LATENCY);
  localparam int unsigned Depth    = 1 << ADDR_BITS;

  state_e                                  state_q, state_d;
  logic [SlotW-1:0]                        ptr_q, ptr_d;
  logic [SlotW-1:0]                        slot_q, slot_d;
  logic [ADDR_BITS-1:0]                    addr_q, addr_d;
  logic [DATA_BITS-1:0]                    wdata_q, wdata_d;
  logic [CntW-1:0]                         cnt_q, cnt_d;
  logic [NUM_CONSUMERS-1:0]                rd_rdy_q, rd_rdy_d;
  logic [NUM_CONSUMERS-1:0]                wr_rdy_q, wr_rdy_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic [DATA_BITS-1:0]                    mem_q [Depth];

  logic [NumSlots-1:0] req;
  logic [NumSlots-1:0] arb_gnt;
  logic [SlotW-1:0]    arb_idx;
  logic                arb_vld;
  logic [ChW-1:0]      arb_ch;
  logic [ChW-1:0]      cur_ch;
  logic                cur_valid;
  logic                mem_we;

  for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_req
    assign req[2*i]   = consumer_read_valid[i];
    assign req[2*i+1] = consumer_write_valid[i] & WRITABLE;
  end

  rr_arbiter #(
    .N (NumSlots)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .en_i  (state_q == StIdle),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign arb_vld   = |arb_gnt;
  assign arb_ch    = ChW'(arb_idx >> 1);
  assign cur_ch    = ChW'(slot_q >> 1);
  assign cur_valid = slot_q[0] ? consumer_write_valid[cur_ch] : consumer_read_valid[cur_ch];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    slot_d    = slot_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rd_rdy_d  = rd_rdy_q;
    wr_rdy_d  = wr_rdy_q;
    rd_data_d = rd_data_q;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_vld) begin
          slot_d  = arb_idx;
          addr_d  = arb_idx[0] ? consumer_write_address[arb_ch] : consumer_read_address[arb_ch];
          wdata_d = consumer_write_data[arb_ch];
          cnt_d   = CntW'(LATENCY - 1);
          ptr_d   = (arb_idx == SlotW'(NumSlots - 1)) ? '0 : arb_idx + 1'b1;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          if (slot_q[0]) begin
            mem_we           = 1'b1;
            wr_rdy_d[cur_ch] = 1'b1;
          end else begin
            rd_data_d[cur_ch] = mem_q[addr_q];
            rd_rdy_d[cur_ch]  = 1'b1;
          end
          state_d = StRespond;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRespond: begin
        // Valid already low on entry still gives one full ready cycle.
        if (!cur_valid) begin
          rd_rdy_d = '0;
          wr_rdy_d = '0;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      slot_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rd_rdy_q  <= '0;
      wr_rdy_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      slot_q    <= slot_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rd_rdy_q  <= rd_rdy_d;
      wr_rdy_q  <= wr_rdy_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Array contents survive reset; preload only lands while idle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end else if (init_write_en && state_q == StIdle) begin
      mem_q[init_address] <= init_data;
    end
  end

  assign consumer_read_ready  = rd_rdy_q;
  assign consumer_write_ready = wr_rdy_q;
  assign consumer_read_data   = rd_data_q;
  assign busy                 = (state_q != StIdle);

endmodule
